parallel_threshold_ctrl: RTL

- Controller and write-merger for NUM_LANES parallel box-filter/threshold lanes in the adaptive-thresholding pipeline.
- Launches lanes with a configurable stagger and latches the threshold offset C at start.
- Buffers each lane's pixel writes in a per-lane FIFO, merges them through a round-robin arbiter onto one VGA-memory write port, and reports completion.
- Simultaneous lane writes are serialised in order; writes are never lost by a fixed-priority mux.

---
 rtl/parallel_threshold_ctrl_pkg.sv | 20 ++
 rtl/parallel_threshold_ctrl_fifo.sv | 60 ++++++
 rtl/parallel_threshold_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/parallel_threshold_ctrl_pkg.sv
// Shared types for the adaptive-threshold lane controller: FSM state codes
// and the per-lane FIFO entry layout {x, y, pixel}.
package threshold_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int DEF_COORD_BITS = 8;
    localparam int ENTRY_W        = 2 * DEF_COORD_BITS + 1;

    function automatic int entry_width(input int coord_bits);
        return 2 * coord_bits + 1;
    endfunction

endpackage

// File: rtl/parallel_threshold_ctrl_fifo.sv
// Per-lane synchronous FIFO. A push while full is refused even if a pop
// happens in the same cycle; head data is presented combinationally.
module lane_fifo #(
    parameter int W          = 17,
    parameter int DEPTH_BITS = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [W-1:0]          mem_r [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_r;
    logic [DEPTH_BITS-1:0] rd_ptr_r;
    logic [DEPTH_BITS:0]   count_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign full      = (count_r == (DEPTH_BITS + 1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/parallel_threshold_ctrl.sv
// Launches the filter lanes with a stagger, latches C, and merges lane
// pixel writes through per-lane FIFOs and a round-robin arbiter.
module parallel_threshold_ctrl
    import threshold_pkg::*;
#(
    parameter int NUM_LANES       = 4,
    parameter int COORD_BITS      = 8,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int STAGGER         = 1,
    parameter int C_BITS          = 5
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [C_BITS-1:0]               iC,
    output logic [C_BITS-1:0]               oC,
    output logic [NUM_LANES-1:0]            oLaneEnable,
    input  logic [NUM_LANES-1:0]            iLaneFinished,
    input  logic [NUM_LANES-1:0]            iLaneWren,
    input  logic [NUM_LANES*COORD_BITS-1:0] iLaneX,
    input  logic [NUM_LANES*COORD_BITS-1:0] iLaneY,
    input  logic [NUM_LANES-1:0]            iLaneData,
    output logic [NUM_LANES-1:0]            oLaneStall,
    output logic [COORD_BITS-1:0]           oX,
    output logic [COORD_BITS-1:0]           oY,
    output logic [2:0]                      oR,
    output logic [2:0]                      oG,
    output logic [2:0]                      oB,
    output logic                            oWren,
    output logic                            oBusy,
    output logic                            oDone,
    output logic                            oOverflow,
    output logic [2:0]                      oState
);

    localparam int EW     = entry_width(COORD_BITS);
    localparam int PTR_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int TICK_W = 16;

    state_t               state_r;
    state_t               state_next_s;
    logic [TICK_W-1:0]    tick_r;
    logic [PTR_W-1:0]     ptr_r;
    logic [PTR_W-1:0]     grant_idx_s;
    logic                 grant_valid_s;
    logic [NUM_LANES-1:0] full_s;
    logic [NUM_LANES-1:0] empty_s;
    logic [NUM_LANES-1:0] pop_s;
    logic [EW-1:0]        head_s [NUM_LANES];
    logic [EW-1:0]        grant_entry_s;
    logic                 start_ok_s;
    logic                 all_empty_s;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        lane_fifo #(
            .W          (EW),
            .DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (iLaneWren[k]),
            .pop   (pop_s[k]),
            .wdata ({iLaneX[k*COORD_BITS +: COORD_BITS],
                     iLaneY[k*COORD_BITS +: COORD_BITS],
                     iLaneData[k]}),
            .rdata (head_s[k]),
            .full  (full_s[k]),
            .empty (empty_s[k])
        );
    end

    assign oLaneStall    = full_s;
    assign all_empty_s   = &empty_s;
    assign start_ok_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign grant_entry_s = head_s[grant_idx_s];
    assign oState        = state_r;
    assign oBusy         = (state_r == ST_LAUNCH) || (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign oDone         = (state_r == ST_DONE);

    // Round-robin search: first non-empty lane at or after the pointer, wrapping.
    always_comb begin : arb_comb
        logic [PTR_W:0]   sum_v;
        logic [PTR_W-1:0] lane_v;
        logic             hit_v;
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sum_v         = {1'b0, ptr_r} + (PTR_W + 1)'(i);
            lane_v        = (sum_v >= (PTR_W + 1)'(NUM_LANES))
                          ? PTR_W'(sum_v - (PTR_W + 1)'(NUM_LANES))
                          : sum_v[PTR_W-1:0];
            hit_v         = !grant_valid_s && !empty_s[lane_v];
            grant_idx_s   = hit_v ? lane_v : grant_idx_s;
            grant_valid_s = grant_valid_s | hit_v;
        end
    end

    // One-hot pop for the granted lane.
    always_comb begin
        pop_s = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            pop_s[k] = grant_valid_s && (grant_idx_s == PTR_W'(k));
        end
    end

    // Next-state logic for the run-control FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next_s = (NUM_LANES > 1) ? ST_LAUNCH : ST_RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LAUNCH: begin
                if (oLaneEnable[NUM_LANES-1]) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_LAUNCH;
                end
            end
            ST_RUN: begin
                if (&iLaneFinished) begin
                    state_next_s = (all_empty_s && !grant_valid_s) ? ST_DONE : ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (all_empty_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Offset latch and staggered lane enables; tick_r counts cycles since start.
    always_ff @(posedge clock) begin
        if (reset) begin
            oC          <= '0;
            oLaneEnable <= '0;
            tick_r      <= '0;
        end else if (start_ok_s) begin
            oC          <= iC;
            oLaneEnable <= NUM_LANES'(1'b1);
            tick_r      <= TICK_W'(1);
        end else if (state_r == ST_LAUNCH) begin
            tick_r <= tick_r + 1'b1;
            for (int k = 1; k < NUM_LANES; k++) begin
                if (tick_r == TICK_W'(k * STAGGER)) begin
                    oLaneEnable[k] <= 1'b1;
                end
            end
        end else if (state_next_s == ST_DONE) begin
            oLaneEnable <= '0;
        end
    end

    // Merged write port, arbiter pointer and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            oWren     <= 1'b0;
            oX        <= '0;
            oY        <= '0;
            oR        <= 3'b000;
            oG        <= 3'b000;
            oB        <= 3'b000;
            ptr_r     <= '0;
            oOverflow <= 1'b0;
        end else begin
            oWren <= grant_valid_s;
            if (grant_valid_s) begin
                oX    <= grant_entry_s[EW-1 -: COORD_BITS];
                oY    <= grant_entry_s[COORD_BITS:1];
                oR    <= {3{grant_entry_s[0]}};
                oG    <= {3{grant_entry_s[0]}};
                oB    <= {3{grant_entry_s[0]}};
                ptr_r <= (grant_idx_s == PTR_W'(NUM_LANES - 1)) ? '0 : grant_idx_s + 1'b1;
            end
            if (|(iLaneWren & full_s)) begin
                oOverflow <= 1'b1;
            end
        end
    end

endmodule
